// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - select/MAC-control sequencer for a valid-mode KxK convolution over an NxN matrix
// Optional cycle counter output cycle_cnt is built when CONV_SEQ_CNT_EN is defined.
module conv_seq_ctrl #(
  parameter int IMG_DIM = 4,
  parameter int KER_DIM = 3,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic [3:0]       s0,
  output logic [3:0]       s1,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             pix_last,
  output logic [1:0]       out_row,
  output logic [1:0]       out_col,
  output logic             busy,
  output logic             done
`ifdef CONV_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int         OUT_DIM = IMG_DIM - KER_DIM + 1;
  localparam logic [1:0] K_LAST  = 2'(KER_DIM - 1);
  localparam logic [1:0] O_LAST  = 2'(OUT_DIM - 1);

  if (IMG_DIM < 2 || IMG_DIM > 4 || KER_DIM < 1 || KER_DIM > IMG_DIM || CNT_W < 1) begin : g_bad_param
    $error("conv_seq_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state, state_d;
  logic [1:0] pr, pc, kr, kc;
  logic [1:0] pr_d, pc_d, kr_d, kc_d;
  logic [3:0] s0_d, s1_d;
  logic [1:0] out_row_d, out_col_d;
  logic       mac_en_d, mac_clr_d, pix_last_d, busy_d, done_d;
  logic       load;
  logic       last_tap;

  // Counters always hold the tap currently shown on the outputs.
  assign last_tap = (kc == K_LAST) && (kr == K_LAST) && (pc == O_LAST) && (pr == O_LAST);

  always_comb begin
    state_d = state;
    pr_d    = pr;
    pc_d    = pc;
    kr_d    = kr;
    kc_d    = kc;
    load    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            pr_d    = 2'd0;
            pc_d    = 2'd0;
            kr_d    = 2'd0;
            kc_d    = 2'd0;
            load    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        S_RUN: begin
          busy_d = 1'b1;
          if (!stall) begin
            if (last_tap) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              load = 1'b1;
              if (kc != K_LAST) begin
                kc_d = kc + 2'd1;
              end else begin
                kc_d = 2'd0;
                if (kr != K_LAST) begin
                  kr_d = kr + 2'd1;
                end else begin
                  kr_d = 2'd0;
                  if (pc != O_LAST) begin
                    pc_d = pc + 2'd1;
                  end else begin
                    pc_d = 2'd0;
                    pr_d = pr + 2'd1;
                  end
                end
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Selects and pixel coordinates hold whenever no new tap is issued.
    s0_d       = load ? {pc_d + kc_d, pr_d + kr_d} : s0;
    s1_d       = load ? {kr_d, kc_d} : s1;
    out_row_d  = load ? pr_d : out_row;
    out_col_d  = load ? pc_d : out_col;
    mac_en_d   = load;
    mac_clr_d  = load && (kr_d == 2'd0) && (kc_d == 2'd0);
    pix_last_d = load && (kr_d == K_LAST) && (kc_d == K_LAST);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      pr       <= 2'd0;
      pc       <= 2'd0;
      kr       <= 2'd0;
      kc       <= 2'd0;
      s0       <= 4'd0;
      s1       <= 4'd0;
      out_row  <= 2'd0;
      out_col  <= 2'd0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      pix_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pr       <= pr_d;
      pc       <= pc_d;
      kr       <= kr_d;
      kc       <= kc_d;
      s0       <= s0_d;
      s1       <= s1_d;
      out_row  <= out_row_d;
      out_col  <= out_col_d;
      mac_en   <= mac_en_d;
      mac_clr  <= mac_clr_d;
      pix_last <= pix_last_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

`ifdef CONV_SEQ_CNT_EN
  // Counts stalled and unstalled RUN cycles; value survives DONE/IDLE for readout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      cycle_cnt <= '0;
    end else if (state == S_RUN && cycle_cnt != {CNT_W{1'b1}}) begin
      cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed scoreboard bench for conv_seq_ctrl at default parameters
module tb_conv_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, start, stall, abort;
  logic [3:0] s0, s1;
  logic       mac_en, mac_clr, pix_last, busy, done;
  logic [1:0] out_row, out_col;
`ifdef CONV_SEQ_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  conv_seq_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .stall    (stall),
    .abort    (abort),
    .s0       (s0),
    .s1       (s1),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .pix_last (pix_last),
    .out_row  (out_row),
    .out_col  (out_col),
    .busy     (busy),
    .done     (done)
`ifdef CONV_SEQ_CNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int rel    = 0;
  int acc    = 0;
  logic [13:0] tap_q[$];
  int          pix_q[$];

  int a_m [4][4] = '{'{1, 2, 3, 4}, '{2, 3, 4, 5}, '{3, 4, 5, 5}, '{3, 4, 5, 5}};
  int b_m [4][4] = '{'{9, 8, 7, 0}, '{8, 7, 6, 0}, '{7, 6, 5, 0}, '{0, 0, 0, 0}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected tap stream {s0, s1, clr, last, row, col} and per-pixel sums for one full run.
  task automatic push_run();
    int sum;
    for (int pr = 0; pr < 2; pr++) begin
      for (int pc = 0; pc < 2; pc++) begin
        sum = 0;
        for (int kr = 0; kr < 3; kr++) begin
          for (int kc = 0; kc < 3; kc++) begin
            tap_q.push_back({2'(pc + kc), 2'(pr + kr), 2'(kr), 2'(kc),
                             1'(kr == 0 && kc == 0), 1'(kr == 2 && kc == 2), 2'(pr), 2'(pc)});
            sum += a_m[pr + kr][pc + kc] * b_m[kr][kc];
          end
        end
        pix_q.push_back(sum);
      end
    end
  endtask

  task automatic monitor();
    logic [13:0] exp_tap;
    int          prod;
    if (mac_en === 1'b1) begin
      chk("tap_expected", 32'(tap_q.size() != 0), 32'd1);
      if (tap_q.size() != 0) begin
        exp_tap = tap_q.pop_front();
        chk("tap", 32'({s0, s1, mac_clr, pix_last, out_row, out_col}), 32'(exp_tap));
      end
      prod = a_m[s0[1:0]][s0[3:2]] * b_m[s1[3:2]][s1[1:0]];
      acc  = mac_clr ? prod : acc + prod;
      if (pix_last) begin
        chk("pix_expected", 32'(pix_q.size() != 0), 32'd1);
        if (pix_q.size() != 0) chk("pixel_sum", 32'(acc), 32'(pix_q.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    rel++;
    monitor();
  endtask

  task automatic run_to(input int n);
    while (rel < n) tick();
  endtask

  // Caller sits at rel 0; returns at rel 37 (DONE cycle).
  task automatic run_basic(input bit restart20);
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    chk("c1_sel", 32'({s0, s1}), 32'd0);
    chk("c1_ctl", 32'({mac_clr, mac_en, busy}), 32'b111);
    run_to(2);
    chk("c2_sel", 32'({s0, s1}), 32'b0100_0001);
    run_to(4);
    chk("c4_sel", 32'({s0, s1}), 32'b0001_0100);
    run_to(9);
    chk("c9_sel", 32'({s0, s1, pix_last}), 32'b1010_1010_1);
    run_to(10);
    chk("c10_pix", 32'({out_col, s0, s1, mac_clr}), 32'({2'd1, 4'b0100, 4'b0000, 1'b1}));
    if (restart20) begin
      run_to(20);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    run_to(36);
    chk("c36_sel", 32'({s0, s1, pix_last}), 32'b1111_1010_1);
    tick();
    chk("c37_done", 32'({done, busy, mac_en}), 32'b100);
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outs", 32'({s0, s1, mac_en, mac_clr, pix_last, out_row, out_col, busy, done}), 32'd0);
`ifdef CONV_SEQ_CNT_EN
    chk("reset_cnt", 32'(cycle_cnt), 32'd0);
`endif
    RESET = 1'b0;
    tick();

    // Basic run with a start pulse mid-run; start held through DONE and the following IDLE cycle.
    rel = 0;
    run_basic(1'b1);
    start = 1'b1;
    tick();
    chk("c38_idle", 32'({done, busy, mac_en}), 32'd0);
    chk("c38_drained", 32'(tap_q.size() + pix_q.size()), 32'd0);
    push_run();
    rel = 0;
    tick();
    start = 1'b0;
    chk("rerun_c1", 32'({busy, mac_clr, mac_en, s0, s1}), 32'({3'b111, 8'd0}));

    // Stall held so that output cycles 5..7 are frozen on the cycle-4 tap.
    run_to(4);
    stall = 1'b1;
    run_to(5);
    chk("stall_c5", 32'({s0, s1, mac_en, mac_clr, pix_last, busy}), 32'({4'b0001, 4'b0100, 4'b0001}));
    run_to(7);
    chk("stall_c7", 32'({s0, s1, mac_en, busy}), 32'({4'b0001, 4'b0100, 2'b01}));
    stall = 1'b0;
    run_to(8);
    chk("stall_resume", 32'({s0, s1, mac_en}), 32'({4'b0101, 4'b0101, 1'b1}));
    run_to(39);
    chk("stall_c39", 32'({busy, done}), 32'b10);
    run_to(40);
    chk("stall_c40", 32'({busy, done}), 32'b01);
`ifdef CONV_SEQ_CNT_EN
    chk("cycle_cnt", 32'(cycle_cnt), 32'd39);
`endif
    tick();
    chk("stall_c41", 32'({busy, done}), 32'b00);

    // Abort sampled at the edge into cycle 16.
    rel = 0;
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    run_to(15);
    abort = 1'b1;
    tap_q.delete();
    pix_q.delete();
    tick();
    abort = 1'b0;
    chk("abort_c16", 32'({busy, done, mac_en, mac_clr, pix_last}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_idle", 32'({busy, done, mac_en}), 32'd0);
    end

    // Asynchronous reset mid-run.
    rel = 0;
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    run_to(12);
    RESET = 1'b1;
    tap_q.delete();
    pix_q.delete();
    #1;
    chk("rst_c12", 32'({busy, done, mac_en, mac_clr, pix_last, s0, s1, out_row, out_col}), 32'd0);
    tick();
    RESET = 1'b0;
    chk("rst_hold", 32'({busy, done, mac_en}), 32'd0);
    tick();
    chk("rst_idle", 32'({busy, done, mac_en}), 32'd0);

    // Fresh run after reset replays the basic sequence.
    rel = 0;
    run_basic(1'b0);
    tick();
    chk("final_drained", 32'(tap_q.size() + pix_q.size()), 32'd0);
    chk("final_idle", 32'({busy, done}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
